// File: rtl/level_meter.sv
// LED bar-graph back end: instant-attack / stepped-decay bar plus optional peak-hold dot.
// Peak-hold logic is compiled in only when LEVEL_METER_PEAK_EN is defined.
module level_meter #(
    parameter int unsigned BUS_WIDTH    = 6,
    parameter int unsigned DECAY_CYCLES = 16,
    parameter int unsigned HOLD_CYCLES  = 64
) (
    input  logic                 dclk,
    input  logic                 rst_n,
    input  logic [BUS_WIDTH-1:0] level,
    input  logic                 level_valid,
    output logic [7:0]           bar,
    output logic [7:0]           peak_led
);

    localparam logic [15:0] DECAY_LAST = 16'(DECAY_CYCLES - 1);

    logic [BUS_WIDTH-1:0] level_shift;
    logic [3:0]           q;
    logic                 attack;
    logic [3:0]           bar_level_q, bar_level_d;
    logic [15:0]          dcnt_q, dcnt_d;

    // Top three bits of the level select segments 1..8; only a true zero shows nothing.
    always_comb begin
        level_shift = level >> (BUS_WIDTH - 3);
        q           = (level == '0) ? 4'd0 : {1'b0, level_shift[2:0]} + 4'd1;
    end

    always_comb begin
        // NOTE: every _d takes its hold value first so no path leaves it unassigned (no latch).
        bar_level_d = bar_level_q;
        dcnt_d      = dcnt_q;
        attack      = level_valid && (q >= bar_level_q);
        if (attack) begin
            bar_level_d = q;
            dcnt_d      = '0;
        end else if (bar_level_q != 4'd0) begin
            if (dcnt_q == DECAY_LAST) begin
                bar_level_d = bar_level_q - 4'd1;
                dcnt_d      = '0;
            end else begin
                dcnt_d = dcnt_q + 16'd1;
            end
        end else begin
            dcnt_d = '0;
        end
    end

    // NOTE: registered state is updated only with non-blocking assignments.
    always_ff @(posedge dclk or negedge rst_n) begin
        if (!rst_n) begin
            bar_level_q <= '0;
            dcnt_q      <= '0;
        end else begin
            bar_level_q <= bar_level_d;
            dcnt_q      <= dcnt_d;
        end
    end

    always_comb begin
        bar = '0;
        for (int i = 0; i < 8; i++) begin
            bar[i] = (4'(i) < bar_level_q);
        end
    end

`ifdef LEVEL_METER_PEAK_EN
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HOLD = 2'd1;
    localparam logic [1:0] FALL = 2'd2;

    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  peak_level_q, peak_level_d;
    logic [15:0] pcnt_q, pcnt_d;
    logic        capture;

    always_comb begin
        state_d      = state_q;
        peak_level_d = peak_level_q;
        pcnt_d       = pcnt_q;
        capture      = level_valid && (q != 4'd0) && (q >= peak_level_q);
        if (capture) begin
            peak_level_d = q;
            pcnt_d       = '0;
            state_d      = HOLD;
        end else begin
            case (state_q)
                HOLD: begin
                    if (pcnt_q == HOLD_LAST) begin
                        pcnt_d  = '0;
                        state_d = FALL;
                    end else begin
                        pcnt_d = pcnt_q + 16'd1;
                    end
                end
                FALL: begin
                    if (pcnt_q == DECAY_LAST) begin
                        pcnt_d = '0;
                        // The dot never drops onto or below the live bar.
                        if (peak_level_q > bar_level_q) begin
                            peak_level_d = peak_level_q - 4'd1;
                            if (peak_level_q == 4'd1) begin
                                state_d = IDLE;
                            end
                        end
                    end else begin
                        pcnt_d = pcnt_q + 16'd1;
                    end
                end
                default: begin
                    state_d      = IDLE;
                    peak_level_d = '0;
                    pcnt_d       = '0;
                end
            endcase
        end
    end

    always_ff @(posedge dclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            peak_level_q <= '0;
            pcnt_q       <= '0;
        end else begin
            state_q      <= state_d;
            peak_level_q <= peak_level_d;
            pcnt_q       <= pcnt_d;
        end
    end

    always_comb begin
        peak_led = '0;
        for (int i = 0; i < 8; i++) begin
            peak_led[i] = (peak_level_q == 4'(i + 1));
        end
    end
`else
    // HOLD_CYCLES has no consumer when the dot is compiled out.
    logic unused_hold;
    assign unused_hold = ^HOLD_CYCLES;
    assign peak_led    = '0;
`endif

endmodule

// File: tb/tb_level_meter.sv
// Scoreboard bench for level_meter (BUS_WIDTH=6, DECAY_CYCLES=4, HOLD_CYCLES=10).
// Expected peak dot is all-zero unless LEVEL_METER_PEAK_EN is defined.
module tb_level_meter;

    localparam int DEC  = 4;
    localparam int HOLD = 10;
`ifdef LEVEL_METER_PEAK_EN
    localparam bit PEAK_ON = 1'b1;
`else
    localparam bit PEAK_ON = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] bar;
        logic [7:0] peak;
    } exp_t;

    logic       dclk;
    logic       rst_n;
    logic [5:0] level;
    logic       level_valid;
    logic [7:0] bar;
    logic [7:0] peak_led;

    exp_t exp_q[$];
    exp_t e;
    int   tests_run;
    int   tests_failed;

    level_meter #(
        .BUS_WIDTH   (6),
        .DECAY_CYCLES(DEC),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .dclk       (dclk),
        .rst_n      (rst_n),
        .level      (level),
        .level_valid(level_valid),
        .bar        (bar),
        .peak_led   (peak_led)
    );

    initial dclk = 1'b0;
    always #5 dclk = ~dclk;

    function automatic int clamp0(input int v);
        return (v < 0) ? 0 : v;
    endfunction

    function automatic logic [7:0] thermo(input int n);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) if (i < n) r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [7:0] dot(input int n);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) if (PEAK_ON && (i == n - 1)) r[i] = 1'b1;
        return r;
    endfunction

    // Dot position k cycles after a lone capture at p, with the bar already below it.
    function automatic int peak_after(input int p, input int k);
        if (k < HOLD) return p;
        return clamp0(p - (k - HOLD) / DEC);
    endfunction

    task automatic tick(input bit v, input logic [5:0] l);
        level_valid = v;
        level       = l;
        @(posedge dclk);
        #1;
        level_valid = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n       = 1'b0;
        level_valid = 1'b0;
        level       = '0;
        @(posedge dclk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        level_valid = 1'b0;
        level       = '0;
        repeat (3) @(posedge dclk);
        #1;
        exp_q.push_back('{bar: 8'h00, peak: 8'h00});
        e = exp_q.pop_front();
        tests_run++;
        if (bar !== e.bar || peak_led !== e.peak) begin
            tests_failed++;
            $display("FAIL reset_power_on bar=%h peak=%h expected %h %h", bar, peak_led, e.bar, e.peak);
        end
        rst_n = 1'b1;
        exp_q.push_back('{bar: 8'hFF, peak: dot(8)});
        tick(1'b1, 6'd63);
        tick(1'b0, 6'd0);
        tick(1'b0, 6'd0);
        e = exp_q.pop_front();
        tests_run++;
        if (bar !== e.bar || peak_led !== e.peak) begin
            tests_failed++;
            $display("FAIL reset_pre bar=%h peak=%h expected %h %h", bar, peak_led, e.bar, e.peak);
        end
        // Asynchronous assertion between edges.
        #3 rst_n = 1'b0;
        #1;
        exp_q.push_back('{bar: 8'h00, peak: 8'h00});
        e = exp_q.pop_front();
        tests_run++;
        if (bar !== e.bar || peak_led !== e.peak) begin
            tests_failed++;
            $display("FAIL reset_async bar=%h peak=%h expected %h %h", bar, peak_led, e.bar, e.peak);
        end
        @(posedge dclk);
        #1;
        rst_n = 1'b1;
        exp_q.push_back('{bar: thermo(3), peak: dot(3)});
        tick(1'b1, 6'd20);
        e = exp_q.pop_front();
        tests_run++;
        if (bar !== e.bar || peak_led !== e.peak) begin
            tests_failed++;
            $display("FAIL reset_first_edge bar=%h peak=%h expected %h %h", bar, peak_led, e.bar, e.peak);
        end
    endtask

    task automatic test_attack();
        apply_reset();
        for (int k = 0; k <= 4; k++) begin
            exp_q.push_back('{bar: thermo(8 - k / DEC), peak: dot(8)});
            if (k == 0) tick(1'b1, 6'd63);
            else if (k == 1) tick(1'b1, 6'd20);
            else tick(1'b0, 6'd0);
            e = exp_q.pop_front();
            tests_run++;
            if (bar !== e.bar || peak_led !== e.peak) begin
                tests_failed++;
                $display("FAIL attack k=%0d bar=%h peak=%h expected %h %h", k, bar, peak_led, e.bar, e.peak);
            end
        end
    endtask

    task automatic test_decay();
        apply_reset();
        for (int k = 0; k <= 44; k++) begin
            exp_q.push_back('{bar: thermo(clamp0(8 - k / DEC)), peak: dot(peak_after(8, k))});
            tick(k == 0, 6'd63);
            e = exp_q.pop_front();
            tests_run++;
            if (bar !== e.bar || peak_led !== e.peak) begin
                tests_failed++;
                $display("FAIL decay k=%0d bar=%h peak=%h expected %h %h", k, bar, peak_led, e.bar, e.peak);
            end
            if (k >= 32) begin
                tests_run++;
                if (dut.dcnt_q !== 16'd0) begin
                    tests_failed++;
                    $display("FAIL decay_dcnt_held k=%0d dcnt=%0d expected 0", k, dut.dcnt_q);
                end
            end
        end
    endtask

    task automatic test_peak_hold();
        apply_reset();
        for (int k = 0; k <= 36; k++) begin
            exp_q.push_back('{bar: thermo(clamp0(6 - k / DEC)), peak: dot(peak_after(6, k))});
            tick(k == 0, 6'd40);
            e = exp_q.pop_front();
            tests_run++;
            if (bar !== e.bar || peak_led !== e.peak) begin
                tests_failed++;
                $display("FAIL peak_hold k=%0d bar=%h peak=%h expected %h %h", k, bar, peak_led, e.bar, e.peak);
            end
        end
    endtask

    // Bar pinned at 7 by repeated strobes: the dot falls to 7 and must stop there.
    task automatic test_peak_suppress();
        apply_reset();
        for (int k = 0; k <= 30; k++) begin
            exp_q.push_back('{bar: (k < 4) ? 8'hFF : 8'h7F, peak: dot((k < 14) ? 8 : 7)});
            tick(1'b1, (k == 0) ? 6'd63 : 6'd48);
            e = exp_q.pop_front();
            tests_run++;
            if (bar !== e.bar || peak_led !== e.peak) begin
                tests_failed++;
                $display("FAIL peak_suppress k=%0d bar=%h peak=%h expected %h %h", k, bar, peak_led, e.bar, e.peak);
            end
        end
    endtask

    // Re-attack on the exact decay edge (k=4) and mid-interval (k=6).
    task automatic test_simultaneous();
        int nb;
        int np;
        apply_reset();
        for (int k = 0; k <= 30; k++) begin
            nb = (k < 10) ? 3 : clamp0(3 - (k - 6) / DEC);
            np = (k < 20) ? 3 : clamp0(3 - (k - 16) / DEC);
            exp_q.push_back('{bar: thermo(nb), peak: dot(np)});
            tick(k == 0 || k == 4 || k == 6, 6'd16);
            e = exp_q.pop_front();
            tests_run++;
            if (bar !== e.bar || peak_led !== e.peak) begin
                tests_failed++;
                $display("FAIL simultaneous k=%0d bar=%h peak=%h expected %h %h", k, bar, peak_led, e.bar, e.peak);
            end
            if (k == 4 || k == 5) begin
                tests_run++;
                if (dut.dcnt_q !== 16'(k - 4)) begin
                    tests_failed++;
                    $display("FAIL simultaneous_dcnt k=%0d dcnt=%0d expected %0d", k, dut.dcnt_q, k - 4);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] lv[8];
        int         qv[8];
        int         cur;
        lv = '{6'd0, 6'd7, 6'd8, 6'd15, 6'd16, 6'd30, 6'd0, 6'd63};
        qv = '{0, 1, 2, 2, 3, 4, 0, 8};
        apply_reset();
        cur = 0;
        for (int i = 0; i < 8; i++) begin
            if (qv[i] >= cur) cur = qv[i];
            exp_q.push_back('{bar: thermo(cur), peak: dot(cur)});
            tick(1'b1, lv[i]);
            e = exp_q.pop_front();
            tests_run++;
            if (bar !== e.bar || peak_led !== e.peak) begin
                tests_failed++;
                $display("FAIL back_to_back level=%0d bar=%h peak=%h expected %h %h", lv[i], bar, peak_led, e.bar, e.peak);
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_attack();
        test_decay();
        test_peak_hold();
        test_peak_suppress();
        test_simultaneous();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
